// File: rtl/lru_victim_select.sv
// Per-set true-LRU age tracker: touches promote a way to MRU, invalidations demote it to LRU,
// and victim requests return the one-hot LRU way of a set one cycle later.
module lru_victim_select #(
    parameter int NUMBER_OF_WAYS = 4,
    parameter int INDEX_BITS     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    output logic                      ready,
    input  logic                      touch_valid,
    input  logic [INDEX_BITS-1:0]     touch_index,
    input  logic [NUMBER_OF_WAYS-1:0] touch_way,
    input  logic                      inval_valid,
    input  logic [INDEX_BITS-1:0]     inval_index,
    input  logic [NUMBER_OF_WAYS-1:0] inval_way,
    input  logic                      victim_req,
    input  logic [INDEX_BITS-1:0]     victim_index,
    output logic [NUMBER_OF_WAYS-1:0] victim_way,
    output logic                      victim_valid
);

    localparam int AGE_BITS       = (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1;
    localparam int NUMBER_OF_SETS = 2 ** INDEX_BITS;
    localparam int ROW_BITS       = NUMBER_OF_WAYS * AGE_BITS;
    localparam logic [AGE_BITS-1:0] OLDEST = AGE_BITS'(NUMBER_OF_WAYS - 1);

    typedef logic [ROW_BITS-1:0] row_t;
    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [INDEX_BITS-1:0]   init_count;
    row_t                    age_mem [NUMBER_OF_SETS];
    row_t                    reset_row;
    row_t                    touch_row;
    row_t                    inval_row;
    row_t                    victim_row;
    logic [NUMBER_OF_WAYS-1:0] touch_sel;
    logic [NUMBER_OF_WAYS-1:0] inval_sel;
    logic [NUMBER_OF_WAYS-1:0] victim_onehot;
    logic                    touch_en;
    logic                    inval_en;

    function automatic logic [NUMBER_OF_WAYS-1:0] lowest_bit(input logic [NUMBER_OF_WAYS-1:0] v);
        logic [NUMBER_OF_WAYS-1:0] r;
        r = '0;
        for (int i = NUMBER_OF_WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [AGE_BITS-1:0] age_of(input row_t row, input logic [NUMBER_OF_WAYS-1:0] sel);
        logic [AGE_BITS-1:0] a;
        a = '0;
        for (int i = 0; i < NUMBER_OF_WAYS; i++) begin
            if (sel[i]) a = a | row[i*AGE_BITS +: AGE_BITS];
        end
        return a;
    endfunction

    // Promote the selected way to MRU; ways younger than it age by one.
    function automatic row_t touch_update(input row_t row, input logic [NUMBER_OF_WAYS-1:0] sel);
        logic [AGE_BITS-1:0] old;
        logic [AGE_BITS-1:0] a;
        row_t r;
        old = age_of(row, sel);
        r   = row;
        for (int i = 0; i < NUMBER_OF_WAYS; i++) begin
            a = row[i*AGE_BITS +: AGE_BITS];
            if (sel[i])        r[i*AGE_BITS +: AGE_BITS] = '0;
            else if (a < old)  r[i*AGE_BITS +: AGE_BITS] = a + AGE_BITS'(1);
        end
        return r;
    endfunction

    // Demote the selected way to LRU; ways older than it get one step younger.
    function automatic row_t inval_update(input row_t row, input logic [NUMBER_OF_WAYS-1:0] sel);
        logic [AGE_BITS-1:0] old;
        logic [AGE_BITS-1:0] a;
        row_t r;
        old = age_of(row, sel);
        r   = row;
        for (int i = 0; i < NUMBER_OF_WAYS; i++) begin
            a = row[i*AGE_BITS +: AGE_BITS];
            if (sel[i])        r[i*AGE_BITS +: AGE_BITS] = OLDEST;
            else if (a > old)  r[i*AGE_BITS +: AGE_BITS] = a - AGE_BITS'(1);
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_WAYS; gi++) begin : g_way
            assign reset_row[gi*AGE_BITS +: AGE_BITS] = AGE_BITS'(NUMBER_OF_WAYS - 1 - gi);
            assign victim_onehot[gi] = (victim_row[gi*AGE_BITS +: AGE_BITS] == OLDEST);
        end
    endgenerate

    assign ready      = (state == RUN);
    assign touch_sel  = lowest_bit(touch_way);
    assign inval_sel  = lowest_bit(inval_way);
    assign touch_row  = touch_update(age_mem[touch_index], touch_sel);
    assign inval_row  = inval_update(age_mem[inval_index], inval_sel);
    assign victim_row = age_mem[victim_index];

    // A same-set touch takes priority over an invalidate in the same cycle.
    assign touch_en = touch_valid && (|touch_way);
    assign inval_en = inval_valid && (|inval_way) && !(touch_en && (touch_index == inval_index));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            init_count   <= '0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            case (state)
                INIT: begin
                    victim_valid <= 1'b0;
                    if (flush) begin
                        init_count <= '0;
                    end else begin
                        init_count <= init_count + INDEX_BITS'(1);
                        if (&init_count) state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state        <= INIT;
                        init_count   <= '0;
                        victim_valid <= 1'b0;
                    end else begin
                        victim_valid <= victim_req;
                        if (victim_req) victim_way <= victim_onehot;
                    end
                end
                default: begin
                    state        <= INIT;
                    init_count   <= '0;
                    victim_valid <= 1'b0;
                end
            endcase
        end
    end

    // Age rows carry no reset; the init walk rewrites every set before RUN.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            age_mem[init_count] <= reset_row;
        end else if (!flush) begin
            if (touch_en) age_mem[touch_index] <= touch_row;
            if (inval_en) age_mem[inval_index] <= inval_row;
        end
    end

endmodule

// File: tb/tb_lru_victim_select.sv
// Directed bench for lru_victim_select with N=4 ways and 4 sets; expected victims are hand-derived.
module tb_lru_victim_select;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       ready;
    logic       touch_valid;
    logic [1:0] touch_index;
    logic [3:0] touch_way;
    logic       inval_valid;
    logic [1:0] inval_index;
    logic [3:0] inval_way;
    logic       victim_req;
    logic [1:0] victim_index;
    logic [3:0] victim_way;
    logic       victim_valid;

    int checks = 0;
    int errors = 0;

    lru_victim_select #(.NUMBER_OF_WAYS(4), .INDEX_BITS(2)) dut (
        .clock(clock), .reset(reset), .flush(flush), .ready(ready),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way),
        .inval_valid(inval_valid), .inval_index(inval_index), .inval_way(inval_way),
        .victim_req(victim_req), .victim_index(victim_index),
        .victim_way(victim_way), .victim_valid(victim_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_touch(input logic [1:0] idx, input logic [3:0] way);
        touch_valid = 1'b1; touch_index = idx; touch_way = way;
        step();
        touch_valid = 1'b0;
        $display("touch set %0d way %b", idx, way);
    endtask

    task automatic do_inval(input logic [1:0] idx, input logic [3:0] way);
        inval_valid = 1'b1; inval_index = idx; inval_way = way;
        step();
        inval_valid = 1'b0;
        $display("inval set %0d way %b", idx, way);
    endtask

    task automatic query(input logic [1:0] idx, output logic [3:0] w, output logic v);
        victim_req = 1'b1; victim_index = idx;
        step();
        victim_req = 1'b0;
        w = victim_way; v = victim_valid;
        $display("victim set %0d -> valid %b way %b", idx, v, w);
    endtask

    task automatic test_reset();
        logic [3:0] w;
        logic       v;
        reset = 1'b1;
        step(); step();
        checks++;
        if (ready !== 1'b0 || victim_valid !== 1'b0 || victim_way !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b way=%b, want 0 0 0000", ready, victim_valid, victim_way);
        end
        reset = 1'b0;
        victim_req = 1'b1; victim_index = 2'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ready !== (k == 3) || victim_valid !== 1'b0) begin
                errors++;
                $display("FAIL init_walk cycle %0d: ready=%b valid=%b, want ready=%b valid=0", k, ready, victim_valid, (k == 3));
            end
        end
        victim_req = 1'b0;
        query(2'd0, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0001) begin
            errors++;
            $display("FAIL reset_victim: valid=%b way=%b, want 1 0001", v, w);
        end
    endtask

    task automatic test_touch();
        logic [3:0] w;
        logic       v;
        do_touch(2'd1, 4'b0001);
        query(2'd1, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0010) begin
            errors++;
            $display("FAIL touch_single: valid=%b way=%b, want 1 0010", v, w);
        end
        do_touch(2'd1, 4'b0010);
        do_touch(2'd1, 4'b0100);
        do_touch(2'd1, 4'b1000);
        do_touch(2'd1, 4'b0001);
        query(2'd1, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0010) begin
            errors++;
            $display("FAIL touch_sequence: valid=%b way=%b, want 1 0010", v, w);
        end
    endtask

    task automatic test_inval();
        logic [3:0] w;
        logic       v;
        do_touch(2'd2, 4'b0001);
        do_touch(2'd2, 4'b0010);
        do_touch(2'd2, 4'b0100);
        do_touch(2'd2, 4'b1000);
        do_inval(2'd2, 4'b0100);
        query(2'd2, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0100) begin
            errors++;
            $display("FAIL inval_victim: valid=%b way=%b, want 1 0100", v, w);
        end
        query(2'd3, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0001) begin
            errors++;
            $display("FAIL other_set_untouched: valid=%b way=%b, want 1 0001", v, w);
        end
    endtask

    task automatic test_same_cycle();
        logic [3:0] w;
        logic       v;
        touch_valid = 1'b1; touch_index = 2'd0; touch_way = 4'b0001;
        query(2'd0, w, v);
        touch_valid = 1'b0;
        checks++;
        if (v !== 1'b1 || w !== 4'b0001) begin
            errors++;
            $display("FAIL victim_pre_touch: valid=%b way=%b, want 1 0001", v, w);
        end
        query(2'd0, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0010) begin
            errors++;
            $display("FAIL victim_post_touch: valid=%b way=%b, want 1 0010", v, w);
        end
    endtask

    task automatic test_way_select();
        logic [3:0] w;
        logic       v;
        // Set 3 still has reset ordering here.
        touch_valid = 1'b1; touch_index = 2'd3; touch_way = 4'b0001;
        inval_valid = 1'b1; inval_index = 2'd3; inval_way = 4'b0001;
        step();
        touch_valid = 1'b0; inval_valid = 1'b0;
        query(2'd3, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0010) begin
            errors++;
            $display("FAIL touch_beats_inval: valid=%b way=%b, want 1 0010", v, w);
        end
        do_touch(2'd3, 4'b0000);
        query(2'd3, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0010) begin
            errors++;
            $display("FAIL zero_hot_touch: valid=%b way=%b, want 1 0010", v, w);
        end
        do_touch(2'd3, 4'b0110);
        query(2'd3, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0100) begin
            errors++;
            $display("FAIL multi_hot_touch: valid=%b way=%b, want 1 0100", v, w);
        end
    endtask

    task automatic test_dual_index();
        logic [3:0] w;
        logic       v;
        touch_valid = 1'b1; touch_index = 2'd0; touch_way = 4'b0010;
        inval_valid = 1'b1; inval_index = 2'd1; inval_way = 4'b0001;
        step();
        touch_valid = 1'b0; inval_valid = 1'b0;
        query(2'd0, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0100) begin
            errors++;
            $display("FAIL dual_touch_set0: valid=%b way=%b, want 1 0100", v, w);
        end
        query(2'd1, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0001) begin
            errors++;
            $display("FAIL dual_inval_set1: valid=%b way=%b, want 1 0001", v, w);
        end
    endtask

    task automatic test_back_to_back();
        victim_req = 1'b1; victim_index = 2'd2;
        step();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_first: valid=%b way=%b, want 1 0100", victim_valid, victim_way);
        end
        victim_index = 2'd3;
        step();
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_second: valid=%b way=%b, want 1 0100", victim_valid, victim_way);
        end
        victim_index = 2'd1;
        step();
        victim_req = 1'b0;
        checks++;
        if (victim_valid !== 1'b1 || victim_way !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_third: valid=%b way=%b, want 1 0001", victim_valid, victim_way);
        end
        step();
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 4'b0001) begin
            errors++;
            $display("FAIL pulse_and_hold: valid=%b way=%b, want 0 0001", victim_valid, victim_way);
        end
    endtask

    task automatic test_flush();
        logic [3:0] w;
        logic       v;
        do_touch(2'd1, 4'b0001);
        flush = 1'b1; victim_req = 1'b1; victim_index = 2'd1;
        step();
        flush = 1'b0;
        checks++;
        if (ready !== 1'b0 || victim_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_entry: ready=%b valid=%b, want 0 0", ready, victim_valid);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ready !== (k == 3) || victim_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_walk cycle %0d: ready=%b valid=%b, want ready=%b valid=0", k, ready, victim_valid, (k == 3));
            end
        end
        victim_req = 1'b0;
        query(2'd1, w, v);
        checks++;
        if (v !== 1'b1 || w !== 4'b0001) begin
            errors++;
            $display("FAIL flush_victim: valid=%b way=%b, want 1 0001", v, w);
        end
    endtask

    task automatic test_reset_midop();
        victim_req = 1'b1; victim_index = 2'd0;
        step();
        checks++;
        if (victim_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_pulse: valid=%b, want 1", victim_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (victim_valid !== 1'b0 || victim_way !== 4'b0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b way=%b ready=%b, want 0 0000 0", victim_valid, victim_way, ready);
        end
        step();
        checks++;
        if (victim_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_req: valid=%b, want 0", victim_valid);
        end
        victim_req = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%b, want 1", ready);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        touch_valid = 1'b0; touch_index = '0; touch_way = '0;
        inval_valid = 1'b0; inval_index = '0; inval_way = '0;
        victim_req = 1'b0; victim_index = '0;
        test_reset();
        test_touch();
        test_inval();
        test_same_cycle();
        test_way_select();
        test_dual_index();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lru_victim_select.md
Name: lru_victim_select

Overview:
- Per-set true-LRU tracker that picks the way to evict when a set has no empty way. It is the release-side counterpart of the lowest-empty-way allocator.
- The cache controller reports hits and fills as touches and invalidations as releases. It requests a victim way for a set and gets a one-hot way back, in the same one-hot encoding the allocator uses.
- Age state lives in a per-set register array, rewritten by an init walk after reset or flush.

Parameters:
NUMBER_OF_WAYS, 4, ways per set; power of two, >= 2
INDEX_BITS, 8, set index width; NUMBER_OF_SETS = 2**INDEX_BITS
AGE_BITS, log2(NUMBER_OF_WAYS), derived; width of each way's age

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
flush  input  1  pulse; restart init walk (all sets back to reset ordering)
ready  output  1  1 when block accepts touch/inval/victim requests
touch_valid  input  1  mark touch_way as most recently used
touch_index  input  INDEX_BITS  set for touch
touch_way  input  NUMBER_OF_WAYS  one-hot way touched
inval_valid  input  1  mark inval_way as least recently used
inval_index  input  INDEX_BITS  set for invalidate
inval_way  input  NUMBER_OF_WAYS  one-hot way invalidated
victim_req  input  1  request victim for victim_index
victim_index  input  INDEX_BITS  set queried
victim_way  output  NUMBER_OF_WAYS  one-hot victim way, registered
victim_valid  output  1  victim_way valid this cycle

Behaviour:
- Interface: one clock, `clock`; reset is `reset`, asynchronous and active-high.
- Age encoding: age 0 = MRU, age NUMBER_OF_WAYS-1 = LRU. Within a set, ages are always a permutation of 0..N-1.
- Reset ordering of a set: way i has age N-1-i, so way 0 is LRU and way N-1 is MRU.
- FSM has two states: INIT and RUN.
- Reset asserted → state INIT, init counter 0, ready=0, victim_valid=0, victim_way=0.
- INIT: each cycle writes reset ordering to set[counter] and increments the counter. After writing set NUMBER_OF_SETS-1 → RUN and ready=1 on the next cycle. The walk takes exactly NUMBER_OF_SETS cycles after reset deassertion.
- RUN: flush=1 → INIT with counter 0 and ready=0 next cycle. Any same-cycle touch, inval or victim_req is dropped.
- While ready=0, touch, inval and victim_req are ignored and victim_valid stays 0.
- Touch (RUN, touch_valid): let old = age(touch_way).
  - touched way's age → 0.
  - every way in the set with age < old increments.
  - others unchanged.
  - Written at the clock edge.
- Invalidate (RUN, inval_valid): let old = age(inval_way).
  - invalidated way's age → N-1.
  - every way with age > old decrements.
- Way select rules for touch_way and inval_way:
  - zero-hot → operation ignored.
  - multi-hot → lowest set bit used.
- Same cycle, same index, touch and inval both valid: touch applied, inval dropped. Different indices: both applied.
- Victim request: victim_req in RUN → next cycle victim_valid=1 and victim_way = one-hot of the way with age N-1 in victim_index.
  - Latency is 1 cycle; victim_valid is a 1-cycle pulse per request.
  - Back-to-back requests give back-to-back responses.
  - The victim is computed from the state before that cycle's touch/inval. A same-cycle touch to the victim set does not affect the returned way.
- victim_way holds its last value when victim_valid=0; it is cleared only by reset.
- Reset mid-operation: an in-flight victim response is discarded (victim_valid=0 immediately, asynchronously) and the init walk restarts.
- Arithmetic: ages are AGE_BITS wide and never wrap, because the permutation invariant keeps them in range.

Test Plan:
- Reset, N=4, INDEX_BITS=2 → ready=0 for 4 cycles then 1. victim_req index 0 → next cycle victim_valid=1, victim_way=4'b0001.
- Touch way 4'b0001 in set 1, then victim_req set 1 → victim_way=4'b0010. Touch 0010, 0100, 1000, 0001 in order → victim_way=4'b0010.
- Touch all ways of set 2 (order 0001,0010,0100,1000), inval 4'b0100, victim_req set 2 → victim_way=4'b0100. Set 3 is unaffected: its victim is 0001.
- Same cycle: touch set 0 way 0001 and victim_req set 0 → victim_way=4'b0001 (pre-update state). The next victim_req → 4'b0010.
- Same-index touch 0001 and inval 0001 → touch wins, victim=0010. touch_way=0000 → no change. touch_way=0110 → treated as 0010.
- Flush after scrambling set 1 → ready low for 4 cycles, requests in that window produce no victim_valid. Afterwards, victim for set 1 = 0001. Reset asserted the same cycle as victim_req → no victim_valid pulse.
